// File: rtl/lsu_stage_if.sv
// Pipeline-side and cache-side signals of the load/store stage.
// The master view belongs to the stage itself. The slave view is the surrounding pipe
// and data cache.
interface lsu_stage_if #(
    parameter int LINE_BYTES = 16
);
    // EX/MEM request
    logic                    in_valid;
    logic                    in_load;
    logic                    in_store;
    logic [2:0]              in_funct3;
    logic [31:0]             in_addr;
    logic [31:0]             in_wdata;
    logic                    in_flush;

    // Pipe control and WB result
    logic                    stall_req;
    logic                    out_valid;
    logic [31:0]             out_data;
    logic                    out_fault;
    logic [3:0]              out_cause;

    // Data cache port
    logic                    c_valid;
    logic                    c_ready;
    logic                    c_we;
    logic [31:0]             c_addr;
    logic [LINE_BYTES-1:0]   c_wmask;
    logic [8*LINE_BYTES-1:0] c_wdata;
    logic [8*LINE_BYTES-1:0] c_rdata;

    modport master (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_flush,
        input  c_ready, c_rdata,
        output stall_req, out_valid, out_data, out_fault, out_cause,
        output c_valid, c_we, c_addr, c_wmask, c_wdata
    );

    modport slave (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_flush,
        output c_ready, c_rdata,
        input  stall_req, out_valid, out_data, out_fault, out_cause,
        input  c_valid, c_we, c_addr, c_wmask, c_wdata
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage between EX and WB.
// It issues one line-wide cache request per memory instruction. It raises width,
// alignment and window faults without touching the cache. Non-memory results
// pass straight through to WB.
//
// state | meaning
// IDLE  | accept the next instruction; non-memory and faulting ops answer next cycle
// BUSY  | cache request held on c_valid until c_ready, pipe stalled
// DONE  | result pulse to WB, stall released so EX/MEM advances
module lsu_stage #(
    parameter int          LINE_BYTES = 16,
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0004_0000
) (
    input  logic          clk,
    input  logic          rst,
    lsu_stage_if.master   bus
);
    localparam int          LB     = LINE_BYTES;
    localparam int          OFF    = $clog2(LINE_BYTES);
    localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [LB-1:0]   wmask_q;
    logic [8*LB-1:0] wdata_q;
    logic            flushed_q;
    logic            out_valid_q;
    logic            out_fault_q;
    logic [3:0]      out_cause_q;
    logic [31:0]     out_data_q;

    logic            is_load;
    logic            is_mem;
    logic            illegal;
    logic            misal;
    logic            outside;
    logic            fault;
    logic            accept;
    logic [3:0]      cause_d;
    logic [32:0]     nbytes;
    logic [32:0]     a_end;
    logic [OFF-1:0]  off_in;
    logic [OFF-1:0]  line_off;
    logic [LB-1:0]   base_mask;
    logic [LB-1:0]   wmask_d;
    logic [8*LB-1:0] wdata_d;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_word;
    logic [31:0]     load_val;

    assign off_in   = bus.in_addr[OFF-1:0];
    assign line_off = addr_q[OFF-1:0];

    // Decode the incoming instruction: fault classification and line positioning of store data.
    always_comb begin
        is_load   = bus.in_load;
        is_mem    = bus.in_valid & (bus.in_load | bus.in_store);
        illegal   = is_load ? (bus.in_funct3 == 3'd3 || bus.in_funct3 == 3'd6 || bus.in_funct3 == 3'd7)
                            : (bus.in_funct3 >= 3'd3);
        misal     = ((bus.in_funct3[1:0] == 2'd1) & bus.in_addr[0]) |
                    ((bus.in_funct3[1:0] == 2'd2) & (bus.in_addr[1:0] != 2'b00));
        nbytes    = (bus.in_funct3[1:0] == 2'd0) ? 33'd1 :
                    (bus.in_funct3[1:0] == 2'd1) ? 33'd2 : 33'd4;
        // The whole access has to fit in the window, not just its first byte.
        a_end     = {1'b0, bus.in_addr} + nbytes;
        outside   = ({1'b0, bus.in_addr} < WIN_LO) | (a_end > WIN_HI);
        fault     = illegal | misal | outside;
        if (illegal)
            cause_d = 4'd2;
        else if (misal)
            cause_d = is_load ? 4'd4 : 4'd6;
        else
            cause_d = is_load ? 4'd5 : 4'd7;
        accept    = (state_q == IDLE) & is_mem & ~fault & ~bus.in_flush;

        base_mask = '0;
        wdata_d   = '0;
        case (bus.in_funct3[1:0])
            2'd0: begin
                base_mask[0]   = 1'b1;
                wdata_d        = {LB{bus.in_wdata[7:0]}};
            end
            2'd1: begin
                base_mask[1:0] = 2'b11;
                wdata_d        = {(LB/2){bus.in_wdata[15:0]}};
            end
            default: begin
                base_mask[3:0] = 4'hF;
                wdata_d        = {(LB/4){bus.in_wdata}};
            end
        endcase
        wmask_d = is_load ? '0 : (base_mask << off_in);
    end

    // Pick the addressed byte, half and word out of the returned line, then extend.
    always_comb begin
        rd_byte = '0;
        rd_half = '0;
        rd_word = '0;
        for (int i = 0; i < LB; i++)
            if (line_off == OFF'(i)) rd_byte = bus.c_rdata[8*i +: 8];
        for (int i = 0; i < LB/2; i++)
            if (line_off == OFF'(2*i)) rd_half = bus.c_rdata[16*i +: 16];
        for (int i = 0; i < LB/4; i++)
            if (line_off == OFF'(4*i)) rd_word = bus.c_rdata[32*i +: 32];
        case (f3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Request FSM with registered cache request and WB result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wmask_q     <= '0;
            wdata_q     <= '0;
            flushed_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
            out_cause_q <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
            out_cause_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && !bus.in_flush) begin
                        if (!is_mem) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= bus.in_addr;
                        end else if (fault) begin
                            out_valid_q <= 1'b1;
                            out_fault_q <= 1'b1;
                            out_cause_q <= cause_d;
                            out_data_q  <= '0;
                        end else begin
                            we_q      <= ~is_load;
                            f3_q      <= bus.in_funct3;
                            addr_q    <= bus.in_addr;
                            wmask_q   <= wmask_d;
                            wdata_q   <= wdata_d;
                            flushed_q <= 1'b0;
                            state_q   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A flush cannot recall the request; it only hides the result.
                    if (bus.in_flush) flushed_q <= 1'b1;
                    if (bus.c_ready) begin
                        out_valid_q <= ~(flushed_q | bus.in_flush);
                        out_data_q  <= we_q ? 32'd0 : load_val;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle and all of BUSY. It is forced low while reset is held.
    assign bus.stall_req = (state_q == BUSY) | (rst & accept);
    assign bus.out_valid = out_valid_q & ~((state_q == DONE) & bus.in_flush);
    assign bus.out_data  = out_data_q;
    assign bus.out_fault = out_fault_q;
    assign bus.out_cause = out_cause_q;
    assign bus.c_valid   = (state_q == BUSY);
    assign bus.c_we      = we_q;
    assign bus.c_addr    = addr_q;
    assign bus.c_wmask   = wmask_q;
    assign bus.c_wdata   = wdata_q;
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage at 16-byte lines, plus one load on a 32-byte-line instance.
module tb_lsu_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsu_stage_if #(.LINE_BYTES(16)) bus ();
    lsu_stage #(.LINE_BYTES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    lsu_stage_if #(.LINE_BYTES(32)) bus32 ();
    lsu_stage #(.LINE_BYTES(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [3:0]  cause;
    } fvec_t;

    fvec_t fv [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.in_valid  = 1'b0;
        bus.in_load   = 1'b0;
        bus.in_store  = 1'b0;
        bus.in_funct3 = 3'd0;
        bus.in_addr   = 32'd0;
        bus.in_wdata  = 32'd0;
        bus.in_flush  = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.in_valid  = 1'b1;
        bus.in_load   = ld;
        bus.in_store  = st;
        bus.in_funct3 = f3;
        bus.in_addr   = a;
        bus.in_wdata  = wd;
        bus.in_flush  = 1'b0;
    endtask

    initial begin
        fv[0] = '{1'b1, 1'b0, 3'd2, 32'h8000_0002, 4'd4};
        fv[1] = '{1'b0, 1'b1, 3'd2, 32'h8004_0000, 4'd7};
        fv[2] = '{1'b1, 1'b0, 3'd2, 32'h7FFF_FFFC, 4'd5};
        fv[3] = '{1'b1, 1'b0, 3'd3, 32'h7FFF_FFF1, 4'd2};
        fv[4] = '{1'b0, 1'b1, 3'd1, 32'h8000_0003, 4'd6};
        fv[5] = '{1'b1, 1'b0, 3'd1, 32'h8003_FFFF, 4'd4};

        idle_in();
        bus.c_ready = 1'b0;
        bus.c_rdata = '0;
        bus32.in_valid  = 1'b0;
        bus32.in_load   = 1'b0;
        bus32.in_store  = 1'b0;
        bus32.in_funct3 = 3'd0;
        bus32.in_addr   = 32'd0;
        bus32.in_wdata  = 32'd0;
        bus32.in_flush  = 1'b0;
        bus32.c_ready   = 1'b0;
        bus32.c_rdata   = '0;

        step();
        step();
        chk("rst_stall",  {31'd0, bus.stall_req}, 32'd0);
        chk("rst_oval",   {31'd0, bus.out_valid}, 32'd0);
        chk("rst_cval",   {31'd0, bus.c_valid},   32'd0);
        chk("rst_cwe",    {31'd0, bus.c_we},      32'd0);
        chk("rst_caddr",  bus.c_addr,             32'd0);
        chk("rst_wmask",  {16'd0, bus.c_wmask},   32'd0);
        chk("rst_wdata",  bus.c_wdata[31:0],      32'd0);
        rst = 1'b1;

        // lw hitting on the first BUSY cycle
        step();
        drive(1'b1, 1'b0, 3'd2, 32'h8000_0104, 32'd0);
        bus.c_rdata = 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000;
        bus.c_ready = 1'b1;
        #1;
        chk("lw_stall_T",  {31'd0, bus.stall_req}, 32'd1);
        chk("lw_cval_T",   {31'd0, bus.c_valid},   32'd0);
        step();
        chk("lw_cval_T1",  {31'd0, bus.c_valid},   32'd1);
        chk("lw_caddr",    bus.c_addr,             32'h8000_0104);
        chk("lw_cwe",      {31'd0, bus.c_we},      32'd0);
        chk("lw_oval_T1",  {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("lw_oval_T2",  {31'd0, bus.out_valid}, 32'd1);
        chk("lw_data",     bus.out_data,           32'hDEAD_BEEF);
        chk("lw_fault",    {31'd0, bus.out_fault}, 32'd0);
        chk("lw_stall_T2", {31'd0, bus.stall_req}, 32'd0);
        idle_in();
        step();
        chk("lw_oval_T3",  {31'd0, bus.out_valid}, 32'd0);

        // lb / lbu on a byte with the sign bit set
        bus.c_rdata = 128'h0000_0000_0000_0000_8000_0000_0000_0000;
        drive(1'b1, 1'b0, 3'd0, 32'h8000_0107, 32'd0);
        step();
        step();
        chk("lb_data",  bus.out_data, 32'hFFFF_FF80);
        idle_in();
        step();
        drive(1'b1, 1'b0, 3'd4, 32'h8000_0107, 32'd0);
        step();
        step();
        chk("lbu_data", bus.out_data, 32'h0000_0080);
        idle_in();
        step();

        // sh into the middle of the line
        bus.c_ready = 1'b0;
        drive(1'b0, 1'b1, 3'd1, 32'h8000_000A, 32'h0000_1234);
        step();
        chk("sh_wmask", {16'd0, bus.c_wmask},            32'h0000_0C00);
        chk("sh_wdata", {16'd0, bus.c_wdata[95:80]},     32'h0000_1234);
        chk("sh_we",    {31'd0, bus.c_we},               32'd1);
        bus.c_ready = 1'b1;
        step();
        chk("sh_oval",  {31'd0, bus.out_valid},          32'd1);
        chk("sh_data",  bus.out_data,                    32'd0);
        idle_in();
        bus.c_ready = 1'b0;
        step();

        // Faulting ops: never reach the cache, answer next cycle with a cause
        for (int i = 0; i < 6; i++) begin
            drive(fv[i].ld, fv[i].st, fv[i].f3, fv[i].a, 32'd0);
            #1;
            chk($sformatf("flt%0d_stall", i), {31'd0, bus.stall_req}, 32'd0);
            step();
            chk($sformatf("flt%0d_cval", i),  {31'd0, bus.c_valid},   32'd0);
            chk($sformatf("flt%0d_oval", i),  {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("flt%0d_fault", i), {31'd0, bus.out_fault}, 32'd1);
            chk($sformatf("flt%0d_cause", i), {28'd0, bus.out_cause}, {28'd0, fv[i].cause});
            idle_in();
            step();
        end

        // Non-memory pass-through
        drive(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'd0);
        #1;
        chk("alu_stall", {31'd0, bus.stall_req}, 32'd0);
        step();
        chk("alu_oval",  {31'd0, bus.out_valid}, 32'd1);
        chk("alu_data",  bus.out_data,           32'h1234_5678);
        chk("alu_fault", {31'd0, bus.out_fault}, 32'd0);
        idle_in();
        step();

        // Last word of the window is legal
        bus.c_rdata = 128'h1122_3344_0000_0000_0000_0000_0000_0000;
        bus.c_ready = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 32'h8003_FFFC, 32'd0);
        #1;
        chk("edge_stall", {31'd0, bus.stall_req}, 32'd1);
        step();
        step();
        chk("edge_oval",  {31'd0, bus.out_valid}, 32'd1);
        chk("edge_fault", {31'd0, bus.out_fault}, 32'd0);
        chk("edge_data",  bus.out_data,           32'h1122_3344);
        idle_in();
        step();

        // Cache holds off for five cycles
        bus.c_ready = 1'b0;
        bus.c_rdata = 128'h0000_0000_0000_0000_0000_0000_A5A5_5A5A;
        drive(1'b1, 1'b0, 3'd2, 32'h8000_0200, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_cval", i),  {31'd0, bus.c_valid},   32'd1);
            chk($sformatf("hold%0d_caddr", i), bus.c_addr,             32'h8000_0200);
            chk($sformatf("hold%0d_stall", i), {31'd0, bus.stall_req}, 32'd1);
            chk($sformatf("hold%0d_oval", i),  {31'd0, bus.out_valid}, 32'd0);
            step();
        end
        chk("hold_cval_last", {31'd0, bus.c_valid}, 32'd1);
        bus.c_ready = 1'b1;
        step();
        chk("hold_oval", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", bus.out_data,           32'hA5A5_5A5A);
        idle_in();
        bus.c_ready = 1'b0;
        step();

        // Store flushed while BUSY: write still goes out, no result
        drive(1'b0, 1'b1, 3'd2, 32'h8000_0010, 32'hCAFE_F00D);
        step();
        bus.in_flush = 1'b1;
        #1;
        chk("sfl_cval",  {31'd0, bus.c_valid},   32'd1);
        chk("sfl_we",    {31'd0, bus.c_we},      32'd1);
        chk("sfl_wmask", {16'd0, bus.c_wmask},   32'h0000_000F);
        chk("sfl_wdata", bus.c_wdata[31:0],      32'hCAFE_F00D);
        step();
        bus.in_flush = 1'b0;
        chk("sfl_cval2", {31'd0, bus.c_valid},   32'd1);
        bus.c_ready = 1'b1;
        step();
        chk("sfl_oval",  {31'd0, bus.out_valid}, 32'd0);
        idle_in();
        bus.c_ready = 1'b0;
        step();

        // Flush while IDLE drops the instruction
        drive(1'b1, 1'b0, 3'd2, 32'h8000_0104, 32'd0);
        bus.in_flush = 1'b1;
        #1;
        chk("ifl_stall", {31'd0, bus.stall_req}, 32'd0);
        step();
        chk("ifl_cval",  {31'd0, bus.c_valid},   32'd0);
        chk("ifl_oval",  {31'd0, bus.out_valid}, 32'd0);
        idle_in();
        step();

        // Flush in DONE suppresses the result pulse
        bus.c_ready = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 32'h8000_0104, 32'd0);
        step();
        step();
        bus.in_flush = 1'b1;
        #1;
        chk("dfl_oval", {31'd0, bus.out_valid}, 32'd0);
        idle_in();
        bus.c_ready = 1'b0;
        step();

        // Reset asserted in the middle of BUSY
        drive(1'b1, 1'b0, 3'd2, 32'h8000_0104, 32'd0);
        step();
        chk("rb_cval_pre", {31'd0, bus.c_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rb_cval",  {31'd0, bus.c_valid},   32'd0);
        chk("rb_stall", {31'd0, bus.stall_req}, 32'd0);
        chk("rb_oval",  {31'd0, bus.out_valid}, 32'd0);
        chk("rb_caddr", bus.c_addr,             32'd0);
        chk("rb_wmask", {16'd0, bus.c_wmask},   32'd0);
        idle_in();
        step();
        rst = 1'b1;
        step();

        // Same lw on the 32-byte-line instance
        bus32.in_valid  = 1'b1;
        bus32.in_load   = 1'b1;
        bus32.in_funct3 = 3'd2;
        bus32.in_addr   = 32'h8000_0104;
        bus32.c_rdata   = '0;
        bus32.c_rdata[63:32] = 32'hDEAD_BEEF;
        bus32.c_ready   = 1'b1;
        #1;
        chk("l32_stall_T", {31'd0, bus32.stall_req}, 32'd1);
        step();
        chk("l32_cval_T1", {31'd0, bus32.c_valid},   32'd1);
        chk("l32_caddr",   bus32.c_addr,             32'h8000_0104);
        step();
        chk("l32_oval_T2", {31'd0, bus32.out_valid}, 32'd1);
        chk("l32_data",    bus32.out_data,           32'hDEAD_BEEF);
        bus32.in_valid = 1'b0;
        bus32.in_load  = 1'b0;
        step();
        chk("l32_oval_T3", {31'd0, bus32.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
